// File: rtl/arcade_input_ctrl.sv
// Arcade input conditioning: PS/2 + dual joystick merge, orientation remap,
// timed coin pulse from start with hold-off; drives the core's active-low button bus.
module arcade_input_ctrl #(
    parameter int COIN_CYCLES    = 2400000,
    parameter int HOLDOFF_CYCLES = 4800000,
    parameter int CNT_W          = 23
) (
    input  logic        clk_sys,
    input  logic        RESET,
    input  logic [64:0] ps2_key,
    input  logic [15:0] joystick_0,
    input  logic [15:0] joystick_1,
    input  logic        rotate,
    output logic        coin_busy,
    output logic [7:0]  button_n
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PULSE,
        S_HOLDOFF
    } state_t;

    localparam logic [CNT_W-1:0] COIN_LOAD = CNT_W'(COIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF_CYCLES - 1);

    logic             r_primed;
    logic             r_old_toggle;
    logic             r_k_up;
    logic             r_k_down;
    logic             r_k_left;
    logic             r_k_right;
    logic             r_k_space;
    logic             r_k_ctrl;
    logic             r_k_start1;
    logic             r_k_start2;
    logic             r_req_q;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_coin_busy;
    logic [7:0]       r_button_n;

    logic             w_pressed;
    logic             w_ext;
    logic [8:0]       w_code;
    logic             w_event;
    logic             w_valid;
    logic             w_up;
    logic             w_down;
    logic             w_left;
    logic             w_right;
    logic             w_fire;
    logic             w_start1;
    logic             w_start2;
    logic             w_o_up;
    logic             w_o_down;
    logic             w_o_left;
    logic             w_o_right;
    logic             w_req;
    logic             w_rise;
    logic             w_coin;
    logic             w_gate;
    state_t           w_state_nx;
    logic [CNT_W-1:0] w_cnt_nx;
    logic             w_unused;

    assign w_unused  = ^{joystick_0[15:7], joystick_1[15:7]};

    assign w_pressed = (ps2_key[15:8] != 8'hF0);
    assign w_ext     = w_pressed ? (ps2_key[15:8] == 8'hE0)
                                 : (ps2_key[23:16] == 8'hE0);
    assign w_code    = {w_ext, ps2_key[7:0]};
    // primed masks the first cycle so a toggle bit held high through reset is not an event
    assign w_event   = r_primed && (ps2_key[64] != r_old_toggle);
    assign w_valid   = w_event && (ps2_key[63:24] == 40'd0);

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            r_primed     <= 1'b0;
            r_old_toggle <= 1'b0;
            r_k_up       <= 1'b0;
            r_k_down     <= 1'b0;
            r_k_left     <= 1'b0;
            r_k_right    <= 1'b0;
            r_k_space    <= 1'b0;
            r_k_ctrl     <= 1'b0;
            r_k_start1   <= 1'b0;
            r_k_start2   <= 1'b0;
        end else begin
            r_primed     <= 1'b1;
            r_old_toggle <= ps2_key[64];
            if (w_valid) begin
                case (w_code[7:0])
                    8'h75:   r_k_up    <= w_pressed;
                    8'h72:   r_k_down  <= w_pressed;
                    8'h6B:   r_k_left  <= w_pressed;
                    8'h74:   r_k_right <= w_pressed;
                    default: ;
                endcase
                case (w_code)
                    9'h029:  r_k_space  <= w_pressed;
                    9'h014:  r_k_ctrl   <= w_pressed;
                    9'h005:  r_k_start1 <= w_pressed;
                    9'h006:  r_k_start2 <= w_pressed;
                    default: ;
                endcase
            end
        end
    end

    assign w_up     = r_k_up    | joystick_0[3] | joystick_1[3];
    assign w_down   = r_k_down  | joystick_0[2] | joystick_1[2];
    assign w_left   = r_k_left  | joystick_0[1] | joystick_1[1];
    assign w_right  = r_k_right | joystick_0[0] | joystick_1[0];
    assign w_fire   = r_k_space | r_k_ctrl | joystick_0[4] | joystick_1[4];
    assign w_start1 = r_k_start1 | joystick_0[5] | joystick_1[5];
    assign w_start2 = r_k_start2 | joystick_0[6] | joystick_1[6];

    assign w_o_up    = rotate ? w_left  : w_up;
    assign w_o_down  = rotate ? w_right : w_down;
    assign w_o_left  = rotate ? w_down  : w_left;
    assign w_o_right = rotate ? w_up    : w_right;

    assign w_req  = w_start1 | w_start2;
    assign w_rise = w_req & ~r_req_q;

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    w_state_nx = S_PULSE;
                    w_cnt_nx   = COIN_LOAD;
                end
            end
            S_PULSE: begin
                if (r_cnt == '0) begin
                    w_state_nx = S_HOLDOFF;
                    w_cnt_nx   = HOLD_LOAD;
                end else begin
                    w_cnt_nx = r_cnt - 1'b1;
                end
            end
            S_HOLDOFF: begin
                if (r_cnt == '0) begin
                    w_state_nx = S_IDLE;
                end else begin
                    w_cnt_nx = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_req_q <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_req_q <= w_req;
        end
    end

    assign w_coin = (r_state == S_PULSE);
    // Gate on the triggering cycle too, so start never reaches the core ahead of the coin
    assign w_gate = (r_state == S_PULSE) | (w_state_nx == S_PULSE);

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            r_button_n  <= 8'hFF;
            r_coin_busy <= 1'b0;
        end else begin
            r_button_n  <= ~{w_start2 & ~w_gate, w_fire, w_coin,
                             w_start1 & ~w_gate, w_o_right, w_o_left,
                             w_o_down, w_o_up};
            r_coin_busy <= (r_state != S_IDLE);
        end
    end

    assign button_n  = r_button_n;
    assign coin_busy = r_coin_busy;

endmodule

// File: doc/arcade_input_ctrl.md
Name: arcade_input_ctrl

Overview:
- Input-conditioning stage directly upstream of the game core's active-low `button_in` bus.
- Merges PS/2 keyboard events and both MiSTer joysticks.
- Applies the Vert/Horz orientation remap.
- Synthesises a timed coin pulse from either start button, with hold-off, so the core sees a credit before the start press.
- Output is registered and ready to drive `button_in` directly.

Parameters:
- COIN_CYCLES, 2400000, clk_sys cycles the coin line stays asserted (100 ms at 24 MHz); must be >= 2.
- HOLDOFF_CYCLES, 4800000, clk_sys cycles after a coin pulse during which new coin requests are ignored; must be >= 2.
- CNT_W, 23, counter width; must hold max(COIN_CYCLES, HOLDOFF_CYCLES) - 1.

Ports:
- clk_sys  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- ps2_key  in  65  hps_io keyboard word: [64] toggle, [63:24] long-code bytes, [23:16] prefix 2, [15:8] prefix 1, [7:0] scancode
- joystick_0  in  16  player-1 joystick: [0]R [1]L [2]D [3]U [4]fire [5]start1 [6]start2
- joystick_1  in  16  player-2 joystick, same mapping
- rotate  in  1  1 = Horz orientation remap (status[2])
- coin_busy  out  1  high while the FSM is in PULSE or HOLDOFF
- button_n  out  8  active-low {start2, fire, coin, start1, right, left, down, up}

Behaviour:
- Reset (async assert, sync release):
  - button_n = 8'hFF, coin_busy = 0.
  - All key latches = 0, FSM = IDLE, counter = 0.
  - start edge-detect registers = 0; primed = 0.
- PS/2 decode:
  - On the first clock after reset release, primed <= 1 and old_toggle <= ps2_key[64]; no event is generated.
  - Thereafter an event occurs when ps2_key[64] != old_toggle; old_toggle follows every cycle.
  - pressed = (ps2_key[15:8] != 8'hF0).
  - extended = pressed ? (ps2_key[15:8] == 8'hE0) : (ps2_key[23:16] == 8'hE0).
  - code = {extended, ps2_key[7:0]}; events with ps2_key[63:24] != 0 are ignored.
  - Key map, latch <= pressed:
    - x75 up, x72 down, x6B left, x74 right (extended bit ignored)
    - 029 space and 014 ctrl both drive fire
    - 005 F1 = start1, 006 F2 = start2
    - all other codes: no change
- Merge: each direction is key | joystick_0 bit | joystick_1 bit.
- Remap when rotate = 1: up <= left, down <= right, left <= down, right <= up. When rotate = 0, pass through unchanged.
- Coin FSM. req = start1 | start2 (merged); rise = req & ~req_q.
  - IDLE: on rise, go to PULSE with counter = COIN_CYCLES - 1.
  - PULSE: coin = 1. Counter decrements each cycle. At 0, go to HOLDOFF with counter = HOLDOFF_CYCLES - 1.
  - HOLDOFF: coin = 0. Counter decrements each cycle. At 0, go to IDLE.
  - Rises in PULSE or HOLDOFF are dropped, not queued.
  - A rise on the same cycle as the HOLDOFF -> IDLE transition is also dropped; only rises seen while in IDLE trigger.
  - Holding start produces exactly one coin; the button must be released and pressed again.
- Start gating: start1/start2 outputs are forced inactive while the FSM is in PULSE, so start reaches the core only after the coin deasserts. Start is allowed in HOLDOFF and IDLE.
- Output: button_n is registered, = ~{start2_g, fire, coin, start1_g, right, left, down, up}. coin_busy is registered alongside it.
- Latency:
  - Joystick change -> button_n change: 1 clock.
  - PS/2 toggle change -> button_n: 2 clocks (latch, then output register).
  - Start rise -> coin bit low: 2 clocks.
  - Coin stays low for exactly COIN_CYCLES clocks.
- Reset mid-pulse aborts immediately: coin returns high (inactive) and the FSM goes to IDLE.
- Simultaneous joystick and key for the same direction: OR, no conflict.
- Opposite directions held together are passed unchanged; the core resolves them.

Test Plan (use COIN_CYCLES = 4, HOLDOFF_CYCLES = 6):
- Reset with ps2_key[64] = 1, hold 10 clocks, release -> button_n stays 8'hFF; no spurious key event.
- Toggle ps2_key[64] with ps2_key[15:0] = 16'h0075 -> button_n[0] = 0 two clocks later. Toggle again with 16'hF075 -> button_n[0] = 1. Toggle with [63:24] != 0 -> no change.
- rotate = 1, joystick_0 = 16'h0002 (left) -> button_n = 8'hFE (up) after 1 clock. rotate = 0 -> 8'hFB (left).
- joystick_1[5] held 20 clocks:
  - button_n[5] = 0 for exactly 4 clocks; button_n[4] held 1 during the pulse, then 0.
  - coin_busy high for 10 clocks.
  - Only one pulse.
- Second start rise during HOLDOFF -> no second coin. Rise 1 clock after coin_busy falls -> new 4-clock pulse.
- Assert RESET on the 2nd clock of a pulse -> button_n = 8'hFF and coin_busy = 0 asynchronously. After release the FSM is IDLE and a fresh rise yields a full 4-clock pulse.
